design76_result_collector: RTL and testbench

- Sequential capture stage directly downstream of the mapped design76 combinational block.
- Takes the block's 8 result bits each accepted cycle through a valid/ready handshake and buffers them in a small FIFO for the response sink.
- Compresses every accepted vector into an 8-bit MISR signature and counts accepted samples, so a run's result can be checked against a golden signature.

---
 rtl/design76_pkg.sv | 30 +++
 rtl/d76_sync_fifo.sv | 62 ++++++
 rtl/design76_result_collector.sv | 129 ++++++++++++
 tb/tb_design76_result_collector.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/design76_pkg.sv
// Shared definitions for the design76 capture path: result vector layout,
// MISR feedback taps and the collector state encoding.
package design76_pkg;

    // Width of the packed design76 result vector.
    localparam int WIDTH_D76 = 8;

    // Bit positions of each design76 output inside the packed vector.
    // Packed order is {n77,n68,n65,n56,n48,n42,n9,n6}.
    localparam int N6_BIT  = 0;
    localparam int N9_BIT  = 1;
    localparam int N42_BIT = 2;
    localparam int N48_BIT = 3;
    localparam int N56_BIT = 4;
    localparam int N65_BIT = 5;
    localparam int N68_BIT = 6;
    localparam int N77_BIT = 7;

    // Feedback tap mask of the signature register.
    localparam logic [WIDTH_D76-1:0] MISR_POLY_D76 = 8'hB8;

    // Collector run-control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } collector_state_t;

endpackage : design76_pkg

// File: rtl/d76_sync_fifo.sv
// Small synchronous FIFO used as the collector's output buffer.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter. The head is presented
// combinationally and forced to zero while the FIFO is empty.
module d76_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Equal pointers mean empty; equal index with opposite wrap bit means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Overflow and underflow requests are dropped rather than corrupting state.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head of the queue, or zero when there is nothing to show.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer advance; push and pop in one cycle move both and keep occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because dout is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule : d76_sync_fifo

// File: rtl/design76_result_collector.sv
// Capture stage behind the design76 combinational block. Accepted result
// vectors are buffered for the response sink and folded into an MISR
// signature together with a saturating sample count, so a run can be
// compared against a golden signature.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on registered state (RUN and FIFO not
// full), never on in_valid, so no combinational path runs from in_valid to
// in_ready. The upstream keeps in_data stable while in_valid is high and
// in_ready is low. out_valid is high whenever the FIFO holds data; the head
// leaves on any edge where out_ready is also high, in every state.
module design76_result_collector
    import design76_pkg::*;
#(
    parameter int                 WIDTH     = WIDTH_D76,
    parameter int                 DEPTH     = 4,
    parameter int                 CNT_W     = 16,
    parameter logic [WIDTH-1:0]   MISR_POLY = MISR_POLY_D76
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    collector_state_t state;

    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic pop_fire;
    logic run_start;
    logic misr_fb;

    // Accept only while running and while there is room; no bypass path.
    assign in_ready  = (state == RUN) && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop_fire  = out_valid && out_ready;

    // A start pulse only begins a run from IDLE or DONE.
    assign run_start = start && ((state == IDLE) || (state == DONE));

    // MISR feedback bit: parity of the tapped signature bits.
    assign misr_fb = ^(signature & MISR_POLY);

    // Status decodes of the registered state.
    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    d76_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (pop_fire),
        .din   (in_data),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Run control: stop beats start in RUN; DRAIN waits for an empty FIFO,
    // so even an already-empty FIFO spends one cycle in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Signature and sample count: cleared when a run begins, updated on accept,
    // held otherwise. Accepts only occur in RUN, so they never meet a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature  <= '0;
            sample_cnt <= '0;
        end else if (run_start) begin
            signature  <= '0;
            sample_cnt <= '0;
        end else if (accept) begin
            signature <= {signature[WIDTH-2:0], misr_fb} ^ in_data;
            if (sample_cnt != CNT_MAX) begin
                sample_cnt <= sample_cnt + CNT_ONE;
            end
        end
    end

endmodule : design76_result_collector

// File: tb/tb_design76_result_collector.sv
// Bench for design76_result_collector: reset check, a table of per-cycle
// vectors with hand-derived expectations, a randomised run against a
// signature model and a data scoreboard, and an asynchronous reset check.
module tb_design76_result_collector;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  signature;
    logic [15:0] sample_cnt;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  m_sig;
    logic [15:0] m_cnt;
    logic        last_acc;

    typedef struct {
        logic        start;
        logic        stop;
        logic        in_valid;
        logic [7:0]  in_data;
        logic        out_ready;
        logic        e_in_ready;
        logic        e_out_valid;
        logic [7:0]  e_out_data;
        logic        e_busy;
        logic        e_done;
        logic [7:0]  e_sig;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[19];

    design76_result_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .signature  (signature),
        .sample_cnt (sample_cnt),
        .busy       (busy),
        .done       (done)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] misr_model(input logic [7:0] s, input logic [7:0] d);
        logic fb;
        fb = ^(s & 8'hB8);
        return {s[6:0], fb} ^ d;
    endfunction

    function automatic vec_t mk(input logic st, input logic sp, input logic iv,
                                input logic [7:0] id, input logic ordy,
                                input logic eir, input logic eov, input logic [7:0] eod,
                                input logic eb, input logic ed,
                                input logic [7:0] es, input logic [15:0] ec);
        vec_t v;
        v.start = st; v.stop = sp; v.in_valid = iv; v.in_data = id; v.out_ready = ordy;
        v.e_in_ready = eir; v.e_out_valid = eov; v.e_out_data = eod;
        v.e_busy = eb; v.e_done = ed; v.e_sig = es; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard sample just before the edge: pops compare against the queue
    // head, accepts push the driven data and advance the signature model.
    task automatic sb_sample();
        last_acc = 1'b0;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=%0h required=none", out_data);
            end else begin
                chk("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            m_sig = misr_model(m_sig, in_data);
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            last_acc = 1'b1;
        end
    endtask

    // One clock: inputs are already driven; sample, take the edge, settle.
    task automatic tick();
        #1;
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {start,stop,in_valid,in_data,out_ready | in_ready,out_valid,out_data,busy,done,sig,cnt}
        tbl[0]  = mk(1,0,0,8'h00,0, 1,0,8'h00,1,0,8'h00,16'd0);
        tbl[1]  = mk(0,0,1,8'h01,1, 1,1,8'h01,1,0,8'h01,16'd1);
        tbl[2]  = mk(0,0,1,8'h00,1, 1,1,8'h00,1,0,8'h02,16'd2);
        tbl[3]  = mk(0,1,0,8'h00,1, 0,0,8'h00,1,0,8'h02,16'd2);
        tbl[4]  = mk(0,0,0,8'h00,0, 0,0,8'h00,0,1,8'h02,16'd2);
        tbl[5]  = mk(0,1,1,8'hFF,0, 0,0,8'h00,0,1,8'h02,16'd2);
        tbl[6]  = mk(1,0,0,8'h00,0, 1,0,8'h00,1,0,8'h00,16'd0);
        tbl[7]  = mk(0,0,1,8'h80,0, 1,1,8'h80,1,0,8'h80,16'd1);
        tbl[8]  = mk(0,0,1,8'h01,0, 1,1,8'h80,1,0,8'h00,16'd2);
        tbl[9]  = mk(0,0,1,8'h3C,0, 1,1,8'h80,1,0,8'h3C,16'd3);
        tbl[10] = mk(0,0,1,8'h5A,0, 0,1,8'h80,1,0,8'h23,16'd4);
        tbl[11] = mk(0,0,1,8'h77,0, 0,1,8'h80,1,0,8'h23,16'd4);
        tbl[12] = mk(0,0,1,8'h77,1, 1,1,8'h01,1,0,8'h23,16'd4);
        tbl[13] = mk(0,0,1,8'h77,1, 1,1,8'h3C,1,0,8'h30,16'd5);
        tbl[14] = mk(1,1,0,8'h00,0, 0,1,8'h3C,1,0,8'h30,16'd5);
        tbl[15] = mk(0,0,1,8'hAA,1, 0,1,8'h5A,1,0,8'h30,16'd5);
        tbl[16] = mk(0,0,1,8'hAA,1, 0,1,8'h77,1,0,8'h30,16'd5);
        tbl[17] = mk(0,0,1,8'hAA,1, 0,0,8'h00,1,0,8'h30,16'd5);
        tbl[18] = mk(0,0,0,8'h00,0, 0,0,8'h00,0,1,8'h30,16'd5);

        m_sig = 8'h00;
        m_cnt = 16'd0;
        last_acc = 1'b0;

        // Reset with in_valid asserted.
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_signature", {24'd0, signature}, 32'd0);
        chk("rst_sample_cnt", {16'd0, sample_cnt}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven vectors: basic run, restart, full FIFO, push+pop, drain.
        for (int r = 0; r < 19; r++) begin
            start     = tbl[r].start;
            stop      = tbl[r].stop;
            in_valid  = tbl[r].in_valid;
            in_data   = tbl[r].in_data;
            out_ready = tbl[r].out_ready;
            tick();
            chk($sformatf("row%0d_in_ready", r),  {31'd0, in_ready},  {31'd0, tbl[r].e_in_ready});
            chk($sformatf("row%0d_out_valid", r), {31'd0, out_valid}, {31'd0, tbl[r].e_out_valid});
            chk($sformatf("row%0d_out_data", r),  {24'd0, out_data},  {24'd0, tbl[r].e_out_data});
            chk($sformatf("row%0d_busy", r),      {31'd0, busy},      {31'd0, tbl[r].e_busy});
            chk($sformatf("row%0d_done", r),      {31'd0, done},      {31'd0, tbl[r].e_done});
            chk($sformatf("row%0d_signature", r), {24'd0, signature}, {24'd0, tbl[r].e_sig});
            chk($sformatf("row%0d_sample_cnt", r), {16'd0, sample_cnt}, {16'd0, tbl[r].e_cnt});
        end
        start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("table_sb_empty", exp_q.size(), 32'd0);

        // Randomised run from DONE: restart clears, then random traffic.
        start = 1'b1;
        tick();
        start = 1'b0;
        m_sig = 8'h00;
        m_cnt = 16'd0;
        chk("restart_signature", {24'd0, signature}, 32'd0);
        chk("restart_sample_cnt", {16'd0, sample_cnt}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 80; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom_range(0, 255));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            chk("rand_signature", {24'd0, signature}, {24'd0, m_sig});
            chk("rand_sample_cnt", {16'd0, sample_cnt}, {16'd0, m_cnt});
        end
        in_valid = 1'b0;
        stop = 1'b1;
        out_ready = 1'b1;
        tick();
        stop = 1'b0;
        chk("rand_stop_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data = 8'h5C;
        begin
            int n;
            n = 0;
            while (!done && n < 20) begin
                tick();
                n++;
            end
        end
        in_valid = 1'b0;
        chk("rand_drain_done", {31'd0, done}, 32'd1);
        chk("rand_final_signature", {24'd0, signature}, {24'd0, m_sig});
        chk("rand_final_sample_cnt", {16'd0, sample_cnt}, {16'd0, m_cnt});
        chk("rand_sb_empty", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of a run with data queued.
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'hC3; out_ready = 1'b0;
        tick();
        in_data = 8'h5E;
        tick();
        in_valid = 1'b0;
        chk("pre_arst_signature", {24'd0, signature}, {24'd0, misr_model(8'hC3, 8'h5E)});
        chk("pre_arst_out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready",   {31'd0, in_ready},  32'd0);
        chk("arst_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("arst_out_data",   {24'd0, out_data},  32'd0);
        chk("arst_signature",  {24'd0, signature}, 32'd0);
        chk("arst_sample_cnt", {16'd0, sample_cnt}, 32'd0);
        chk("arst_busy",       {31'd0, busy},      32'd0);
        chk("arst_done",       {31'd0, done},      32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11;
        tick();
        in_valid = 1'b0;
        chk("post_arst_idle_in_ready", {31'd0, in_ready}, 32'd0);
        chk("post_arst_idle_out_valid", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_design76_result_collector
